// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN flatten/unflatten stages.
// Holds the FSM state encoding and the index-width helper.
package cnn_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FILL = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      FILL = ST_FILL,
      HOLD = ST_HOLD
   } state_e;

   // Index width for a buffer of 'depth' entries; never below 1 bit.
   function automatic int unsigned idx_width(input int unsigned depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/unflatten.sv
// Serial-to-parallel deserializer assembling a WIDTHxHEIGHT feature map.
// Optional macro UNFLATTEN_ERR_EN adds the 'err' dropped-frame pulse.
module unflatten
   import cnn_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int HEIGHT = 4,
   parameter int N      = 16
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            start,
   input  logic                            in_valid,
   input  logic signed [N-1:0]             in_data,
   output logic                            in_ready,
   output logic signed [N*WIDTH*HEIGHT-1:0] feature_map_flat,
   output logic                            done,
   output logic                            out_valid,
   input  logic                            out_ack
`ifdef UNFLATTEN_ERR_EN
   ,
   output logic                            err
`endif
);

   localparam int DEPTH = WIDTH * HEIGHT;
   localparam int IDXW  = idx_width(DEPTH);
   localparam logic [IDXW-1:0] LAST = IDXW'(DEPTH - 1);

   state_e                  r_state;
   state_e                  w_next;
   logic [IDXW-1:0]         r_idx;
   logic [N*DEPTH-1:0]      r_fmap;
   logic                    r_done;
   logic                    r_out_valid;
   logic                    w_wr;
   logic                    w_last;

   // in_ready comes from the state register only.
   assign in_ready = (r_state == FILL);
   // start has priority, so a word arriving with start is dropped.
   assign w_wr     = in_valid && in_ready && !start;
   assign w_last   = (r_idx == LAST);

   // Next-state decode; start wins over every other event.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (start) w_next = FILL;
         end
         FILL: begin
            if (start)               w_next = FILL;
            else if (w_wr && w_last) w_next = HOLD;
         end
         HOLD: begin
            if (start)        w_next = FILL;
            else if (out_ack) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   // Write index: restarts on start, wraps after the last slot.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  r_idx <= '0;
      else if (start) r_idx <= '0;
      else if (w_wr)  r_idx <= w_last ? '0 : r_idx + 1'b1;
   end

   // Frame buffer: one slot written per accepted word, never cleared.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  r_fmap <= '0;
      else if (w_wr) r_fmap[r_idx*N +: N] <= in_data;
   end

   // Completion pulse, high for the cycle after the last accept.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_done <= 1'b0;
      else          r_done <= w_wr && w_last;
   end

   // Frame-available level: set on completion, cleared by start or ack.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                         r_out_valid <= 1'b0;
      else if (start)                       r_out_valid <= 1'b0;
      else if (w_wr && w_last)              r_out_valid <= 1'b1;
      else if (r_state == HOLD && out_ack)  r_out_valid <= 1'b0;
   end

`ifdef UNFLATTEN_ERR_EN
   logic r_err;

   // Flag a partial frame aborted or a held frame dropped by start.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_err <= 1'b0;
      else          r_err <= start &&
                             ((r_state == FILL && r_idx != '0) ||
                              (r_state == HOLD));
   end

   assign err = r_err;
`endif

   assign feature_map_flat = r_fmap;
   assign done             = r_done;
   assign out_valid        = r_out_valid;

endmodule

// File: tb/tb_unflatten.sv
// Self-checking bench for unflatten against a frame-level model.
// Build with +define+UNFLATTEN_ERR_EN to also cover the err output.
module tb_unflatten;

   localparam int N     = 16;
   localparam int DEPTH = 16;

   logic                    clk;
   logic                    reset_n;
   logic                    start;
   logic                    in_valid;
   logic signed [N-1:0]     in_data;
   logic                    in_ready;
   logic [N*DEPTH-1:0]      feature_map_flat;
   logic                    done;
   logic                    out_valid;
   logic                    out_ack;
   logic                    err;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   logic [N-1:0] mdl [DEPTH];

   unflatten #(.WIDTH(4), .HEIGHT(4), .N(N)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .start            (start),
      .in_valid         (in_valid),
      .in_data          (in_data),
      .in_ready         (in_ready),
      .feature_map_flat (feature_map_flat),
      .done             (done),
      .out_valid        (out_valid),
`ifdef UNFLATTEN_ERR_EN
      .err              (err),
`endif
      .out_ack          (out_ack)
   );

`ifndef UNFLATTEN_ERR_EN
   assign err = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count every completion pulse.
   always @(negedge clk) if (done === 1'b1) done_cnt++;

   function automatic logic [N*DEPTH-1:0] model_flat();
      logic [N*DEPTH-1:0] r;
      r = '0;
      for (int k = 0; k < DEPTH; k++) r[k*N +: N] = mdl[k];
      return r;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic ack_frame();
      out_ack = 1'b1;
      cyc();
      out_ack = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL ack_out_valid got %0b want 0", out_valid);
      end
      checks++;
      if (feature_map_flat !== model_flat()) begin
         errors++;
         $display("FAIL ack_retain got %h want %h", feature_map_flat, model_flat());
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 0; in_valid = 0; in_data = '0; out_ack = 0;
      for (int k = 0; k < DEPTH; k++) mdl[k] = '0;
      #3;
      checks++;
      if (feature_map_flat !== '0 || done !== 1'b0 || out_valid !== 1'b0 ||
          in_ready !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset_outs got fm=%h d=%b v=%b r=%b e=%b want all 0",
                  feature_map_flat, done, out_valid, in_ready, err);
      end
      cyc(); cyc();
      reset_n = 1'b1;
      cyc();
   endtask

   task automatic test_idle_ignore();
      in_valid = 1'b1;
      in_data  = 16'hFFFF;
      for (int i = 0; i < 10; i++) begin
         cyc();
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready cyc %0d got %b want 0", i, in_ready);
         end
         checks++;
         if (feature_map_flat !== '0) begin
            errors++;
            $display("FAIL idle_fm cyc %0d got %h want 0", i, feature_map_flat);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      int d0;
      d0 = done_cnt;
      pulse_start();
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_ready got %b want 1", in_ready);
      end
      for (int k = 0; k < DEPTH; k++) begin
         in_valid = 1'b1;
         in_data  = 16'(k);
         cyc();
         mdl[k] = 16'(k);
         if (k < DEPTH - 1) begin
            checks++;
            if (done !== 1'b0) begin
               errors++;
               $display("FAIL b2b_early_done word %0d got %b want 0", k, done);
            end
         end
      end
      in_valid = 1'b0;
      checks++;
      if (done !== 1'b1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b_complete got d=%b v=%b r=%b want 1 1 0",
                  done, out_valid, in_ready);
      end
      cyc();
      checks++;
      if (done !== 1'b0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_after got d=%b v=%b want 0 1", done, out_valid);
      end
      for (int k = 0; k < DEPTH; k++) begin
         checks++;
         if (feature_map_flat[k*N +: N] !== 16'(k)) begin
            errors++;
            $display("FAIL b2b_word %0d got %h want %h",
                     k, feature_map_flat[k*N +: N], 16'(k));
         end
      end
      checks++;
      if (done_cnt - d0 !== 1) begin
         errors++;
         $display("FAIL b2b_done_count got %0d want 1", done_cnt - d0);
      end
      ack_frame();
   endtask

   task automatic test_gaps();
      logic [N-1:0] w [DEPTH];
      for (int k = 0; k < DEPTH; k++) w[k] = 16'($urandom);
      pulse_start();
      for (int i = 0; i < 2*DEPTH - 1; i++) begin
         in_valid = (i % 2 == 0);
         in_data  = (i % 2 == 0) ? w[i/2] : 16'($urandom);
         cyc();
         if (i % 2 == 0) mdl[i/2] = w[i/2];
         if (i < 2*DEPTH - 2) begin
            checks++;
            if (in_ready !== 1'b1 || done !== 1'b0) begin
               errors++;
               $display("FAIL gap_mid cyc %0d got r=%b d=%b want 1 0",
                        i, in_ready, done);
            end
         end else begin
            checks++;
            if (done !== 1'b1) begin
               errors++;
               $display("FAIL gap_done_latency got %b want 1", done);
            end
         end
      end
      in_valid = 1'b0;
      checks++;
      if (feature_map_flat !== model_flat()) begin
         errors++;
         $display("FAIL gap_frame got %h want %h", feature_map_flat, model_flat());
      end
      ack_frame();
   endtask

   task automatic test_restart();
      int d0;
      d0 = done_cnt;
      pulse_start();
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_data  = 16'h1111;
         cyc();
         mdl[k] = 16'h1111;
      end
      start    = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'hBEEF;
      cyc();
      start    = 1'b0;
      in_valid = 1'b0;
`ifdef UNFLATTEN_ERR_EN
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL restart_err got %b want 1", err);
      end
`endif
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL restart_ready got %b want 1", in_ready);
      end
      for (int k = 0; k < DEPTH; k++) begin
         in_valid = 1'b1;
         in_data  = 16'(16'hA000 + k);
         cyc();
         mdl[k] = 16'(16'hA000 + k);
`ifdef UNFLATTEN_ERR_EN
         checks++;
         if (err !== 1'b0) begin
            errors++;
            $display("FAIL restart_err_clear word %0d got %b want 0", k, err);
         end
`endif
      end
      in_valid = 1'b0;
      cyc();
      checks++;
      if (feature_map_flat !== model_flat()) begin
         errors++;
         $display("FAIL restart_frame got %h want %h", feature_map_flat, model_flat());
      end
      checks++;
      if (done_cnt - d0 !== 1 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL restart_done got cnt=%0d v=%b want 1 1",
                  done_cnt - d0, out_valid);
      end
   endtask

   task automatic test_hold_start_ack();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 16'($urandom);
         cyc();
         checks++;
         if (in_ready !== 1'b0 || feature_map_flat !== model_flat()) begin
            errors++;
            $display("FAIL hold_frozen cyc %0d got r=%b fm=%h want 0 %h",
                     i, in_ready, feature_map_flat, model_flat());
         end
      end
      in_valid = 1'b0;
      start    = 1'b1;
      out_ack  = 1'b1;
      cyc();
      start    = 1'b0;
      out_ack  = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL hold_start_ack got v=%b r=%b d=%b want 0 1 0",
                  out_valid, in_ready, done);
      end
`ifdef UNFLATTEN_ERR_EN
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL hold_err got %b want 1", err);
      end
`endif
      for (int k = 0; k < DEPTH; k++) begin
         in_valid = 1'b1;
         in_data  = 16'($urandom);
         mdl[k]   = in_data;
         cyc();
      end
      in_valid = 1'b0;
      checks++;
      if (feature_map_flat !== model_flat() || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL hold_refill got %h v=%b want %h 1",
                  feature_map_flat, out_valid, model_flat());
      end
      ack_frame();
   endtask

   task automatic test_reset_midframe();
      pulse_start();
      for (int k = 0; k < 8; k++) begin
         in_valid = 1'b1;
         in_data  = 16'($urandom);
         cyc();
      end
      in_valid = 1'b0;
      reset_n  = 1'b0;
      #2;
      for (int k = 0; k < DEPTH; k++) mdl[k] = '0;
      checks++;
      if (feature_map_flat !== '0 || done !== 1'b0 || out_valid !== 1'b0 ||
          in_ready !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL midreset got fm=%h d=%b v=%b r=%b e=%b want all 0",
                  feature_map_flat, done, out_valid, in_ready, err);
      end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = 16'($urandom);
         cyc();
         checks++;
         if (in_ready !== 1'b0 || feature_map_flat !== '0) begin
            errors++;
            $display("FAIL midreset_ignore cyc %0d got r=%b fm=%h want 0 0",
                     i, in_ready, feature_map_flat);
         end
      end
      in_valid = 1'b0;
      pulse_start();
      for (int k = 0; k < DEPTH; k++) begin
         in_valid = 1'b1;
         in_data  = 16'($urandom);
         mdl[k]   = in_data;
         cyc();
      end
      in_valid = 1'b0;
      checks++;
      if (done !== 1'b1 || feature_map_flat !== model_flat()) begin
         errors++;
         $display("FAIL midreset_frame got d=%b fm=%h want 1 %h",
                  done, feature_map_flat, model_flat());
      end
      ack_frame();
   endtask

   task automatic test_random();
      for (int f = 0; f < 3; f++) begin
         int got;
         int n;
         pulse_start();
         got = 0;
         n   = 0;
         while (got < DEPTH && n < 200) begin
            logic         v;
            logic [N-1:0] d;
            v = 1'($urandom_range(0, 1));
            d = 16'($urandom);
            in_valid = v;
            in_data  = d;
            checks++;
            if (in_ready !== 1'b1) begin
               errors++;
               $display("FAIL rnd_ready frame %0d word %0d got %b want 1",
                        f, got, in_ready);
            end
            cyc();
            if (v) begin
               mdl[got] = d;
               got++;
            end
            n++;
         end
         in_valid = 1'b0;
         checks++;
         if (got != DEPTH) begin
            errors++;
            $display("FAIL rnd_timeout frame %0d got %0d words want %0d",
                     f, got, DEPTH);
         end
         checks++;
         if (done !== 1'b1 || out_valid !== 1'b1 ||
             feature_map_flat !== model_flat()) begin
            errors++;
            $display("FAIL rnd_frame %0d got d=%b v=%b fm=%h want 1 1 %h",
                     f, done, out_valid, feature_map_flat, model_flat());
         end
         repeat ($urandom_range(0, 3)) cyc();
         ack_frame();
      end
   endtask

   initial begin
      test_reset();
      test_idle_ignore();
      test_back_to_back();
      test_gaps();
      test_restart();
      test_hold_start_ack();
      test_reset_midframe();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
